// File: rtl/key_scan_pkg.sv
// Shared key definitions for the push-button scanner and the key controller.
//   KEY_W          : width of the one-hot key bus
//   KEY_*          : one-hot key codes (bit4 MENU .. bit0 DOWN)
//   key_state_e    : scanner FSM state encoding
//   is_onehot      : true when exactly one bit of a key vector is set
package key_scan_pkg;

  localparam int unsigned KEY_W = 5;

  localparam logic [KEY_W-1:0] KEY_NONE   = 5'b00000;
  localparam logic [KEY_W-1:0] KEY_MENU   = 5'b10000;
  localparam logic [KEY_W-1:0] KEY_SET    = 5'b01000;
  localparam logic [KEY_W-1:0] KEY_CANCEL = 5'b00100;
  localparam logic [KEY_W-1:0] KEY_UP     = 5'b00010;
  localparam logic [KEY_W-1:0] KEY_DOWN   = 5'b00001;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_e;

  function automatic logic is_onehot(input logic [KEY_W-1:0] v);
    return (v != KEY_NONE) && ((v & (v - KEY_W'(1))) == KEY_NONE);
  endfunction

endpackage

// File: rtl/key_scan_sync.sv
// Two-flop synchronizer for the raw push-button lines; resets to all-ones
// so that every button reads as released coming out of reset.
//   CLK, RESETN : clock, synchronous active-low reset
//   d_i         : asynchronous active-low buttons
//   q_o         : synchronized buttons (still active-low)
module key_sync
  import key_scan_pkg::*;
(
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [KEY_W-1:0] d_i,
  output logic [KEY_W-1:0] q_o
);

  logic [KEY_W-1:0] meta_q;
  logic [KEY_W-1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_scan.sv
// Debounced 5-key push-button scanner with auto-repeat on UP/DOWN.
//   CLK, RESETN : clock, synchronous active-low reset
//   BTN_N       : raw active-low buttons (MENU, SET, CANCEL, UP, DOWN)
//   KEY         : debounced one-hot level of the accepted key
//   KEY_PULSE   : one-cycle strobe per accepted press and per auto-repeat
//   BUSY        : scanner is not idle
module key_scan
  import key_scan_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 20000,
  parameter int unsigned REPEAT_DELAY = 10000000,
  parameter int unsigned REPEAT_RATE  = 2000000
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [KEY_W-1:0] BTN_N,
  output logic [KEY_W-1:0] KEY,
  output logic [KEY_W-1:0] KEY_PULSE,
  output logic             BUSY
);

  localparam int unsigned MAX_AB = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_P  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
  localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'((DEB_CYCLES   == 0) ? 0 : DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'((REPEAT_RATE  == 0) ? 0 : REPEAT_RATE - 1);
  localparam logic             REP_EN     = (REPEAT_DELAY != 0);

  // Counters hold at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [KEY_W-1:0] btn_sync;
  logic [KEY_W-1:0] raw_c;

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             rep_phase_q, rep_phase_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             rep_key_c;
  logic [CNT_W-1:0] rep_last_c;

  key_sync u_sync (
    .CLK    (CLK),
    .RESETN (RESETN),
    .d_i    (BTN_N),
    .q_o    (btn_sync)
  );

  assign raw_c      = ~btn_sync;
  assign rep_key_c  = REP_EN && ((cand_q == KEY_UP) || (cand_q == KEY_DOWN));
  // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE.
  assign rep_last_c = rep_phase_q ? RATE_LAST : DELAY_LAST;

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      rep_phase_q <= 1'b0;
      cand_q      <= KEY_NONE;
      key_q       <= KEY_NONE;
      pulse_q     <= KEY_NONE;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      rep_phase_q <= rep_phase_d;
      cand_q      <= cand_d;
      key_q       <= key_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    rep_phase_d = rep_phase_q;
    cand_d      = cand_q;
    key_d       = KEY_NONE;
    pulse_d     = KEY_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (is_onehot(raw_c)) begin
          cand_d  = raw_c;
          cnt_d   = '0;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (raw_c != cand_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_LAST) begin
          state_d     = ST_PRESSED;
          key_d       = cand_q;
          pulse_d     = cand_q;
          rcnt_d      = '0;
          rep_phase_d = 1'b0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_PRESSED: begin
        if (raw_c != cand_q) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          key_d = cand_q;
          if (rep_key_c) begin
            if (rcnt_q == rep_last_c) begin
              pulse_d     = cand_q;
              rcnt_d      = '0;
              rep_phase_d = 1'b1;
            end else begin
              rcnt_d = sat_inc(rcnt_q);
            end
          end
        end
      end
      ST_RELEASE: begin
        if (raw_c != KEY_NONE) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign KEY       = key_q;
  assign KEY_PULSE = pulse_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_key_scan.sv
// Self-checking bench for key_scan with DEB_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_RATE=5. A run-length model predicts KEY/KEY_PULSE/BUSY each cycle.
module tb_key_scan;

  localparam int DEB   = 4;
  localparam int DELAY = 10;
  localparam int RATE  = 5;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [4:0] BTN_N = 5'b11111;
  logic [4:0] KEY;
  logic [4:0] KEY_PULSE;
  logic       BUSY;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  bit chk_en = 1'b0;

  key_scan #(
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (DELAY),
    .REPEAT_RATE  (RATE)
  ) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .BTN_N     (BTN_N),
    .KEY       (KEY),
    .KEY_PULSE (KEY_PULSE),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  // Behavioural model: raw is BTN_N delayed two edges and inverted; a key is
  // accepted after DEB+1 consecutive edges of the same one-hot raw value,
  // repeats at t = DELAY + k*RATE, and after any change the bus is locked
  // until DEB consecutive all-released edges have been seen.
  logic [4:0] m_s1, m_s2, m_runval, m_key, m_pulse;
  int  m_run, m_t, m_quiet;
  bit  m_held, m_wait;
  wire m_busy = m_held || m_wait || (m_run > 0);

  always @(posedge CLK) begin
    logic [4:0] r;
    if (!RESETN) begin
      m_s1 = 5'b11111; m_s2 = 5'b11111;
      m_held = 0; m_wait = 0; m_run = 0; m_t = 0; m_quiet = 0;
      m_key = 5'b0; m_pulse = 5'b0; m_runval = 5'b0;
    end else begin
      r = ~m_s2;
      m_s2 = m_s1;
      m_s1 = BTN_N;
      m_pulse = 5'b0;
      if (m_held) begin
        if (r == m_key) begin
          m_t++;
          if ((m_key == 5'b00010 || m_key == 5'b00001) && m_t >= DELAY &&
              ((m_t - DELAY) % RATE) == 0)
            m_pulse = m_key;
        end else begin
          m_held = 0; m_wait = 1; m_quiet = 0; m_key = 5'b0;
        end
      end else if (m_wait) begin
        m_quiet = (r == 5'b0) ? m_quiet + 1 : 0;
        if (m_quiet == DEB) begin
          m_wait = 0; m_run = 0;
        end
      end else begin
        if (m_run > 0 && r == m_runval) m_run++;
        else if (m_run == 0 && $onehot(r)) begin m_run = 1; m_runval = r; end
        else m_run = 0;
        if (m_run == DEB + 1) begin
          m_held = 1; m_t = 0; m_key = m_runval; m_pulse = m_runval; m_run = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("key", KEY, m_key);
      check("key_pulse", KEY_PULSE, m_pulse);
      check("busy", {4'b0, BUSY}, {4'b0, m_busy});
      check("onehot", {4'b0, ($onehot0(KEY) && $onehot0(KEY_PULSE))}, 5'd1);
      if (KEY_PULSE != 5'b0) pulse_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    tick(3);
    check("reset_key", KEY, 5'b0);
    check("reset_pulse", KEY_PULSE, 5'b0);
    check("reset_busy", {4'b0, BUSY}, 5'b0);
    chk_en = 1'b1;
    RESETN = 1'b1;
    tick(5);

    // MENU held: single pulse at p+6, nothing more while held.
    BTN_N = 5'b01111;
    tick(6);
    check("menu_early", KEY, 5'b0);
    tick(1);
    check("menu_key", KEY, 5'b10000);
    check("menu_pulse", KEY_PULSE, 5'b10000);
    tick(1);
    check("menu_pulse_once", KEY_PULSE, 5'b0);
    tick(100);
    BTN_N = 5'b11111;
    tick(10);

    // UP held 40 cycles: pulses at p+6, p+16, p+21, ...
    BTN_N = 5'b11101;
    tick(7);
    check("up_first", KEY_PULSE, 5'b00010);
    tick(9);
    check("up_gap", KEY_PULSE, 5'b0);
    tick(1);
    check("up_rep1", KEY_PULSE, 5'b00010);
    tick(5);
    check("up_rep2", KEY_PULSE, 5'b00010);
    tick(18);
    BTN_N = 5'b11111;
    tick(10);

    // SET toggling every 2 cycles is never accepted.
    for (int i = 0; i < 5; i++) begin
      BTN_N = 5'b10111; tick(2);
      BTN_N = 5'b11111; tick(2);
    end
    check("toggle_key", KEY, 5'b0);
    tick(6);

    // MENU then MENU+SET forces release; fresh SET accepted afterwards.
    BTN_N = 5'b01111;
    tick(10);
    check("menu2_key", KEY, 5'b10000);
    BTN_N = 5'b00111;
    tick(3);
    check("two_keys_drop", KEY, 5'b0);
    check("two_keys_busy", {4'b0, BUSY}, 5'd1);
    tick(5);
    BTN_N = 5'b11111;
    tick(3);
    check("release_busy", {4'b0, BUSY}, 5'd1);
    tick(5);
    check("release_idle", {4'b0, BUSY}, 5'd0);
    BTN_N = 5'b10111;
    tick(7);
    check("set_after", KEY, 5'b01000);
    BTN_N = 5'b11111;
    tick(10);

    // Reset mid-press on DOWN: press discarded, then re-debounced.
    BTN_N = 5'b11110;
    tick(10);
    check("down_key", KEY, 5'b00001);
    RESETN = 1'b0;
    tick(1);
    RESETN = 1'b1;
    check("rst_key", KEY, 5'b0);
    check("rst_pulse", KEY_PULSE, 5'b0);
    check("rst_busy", {4'b0, BUSY}, 5'b0);
    tick(6);
    check("rst_redeb_early", KEY, 5'b0);
    tick(1);
    check("rst_redeb", KEY, 5'b00001);
    BTN_N = 5'b11111;
    tick(10);

    // SET press with release chatter: one pulse, idle after 4 clean cycles.
    pulse_cnt = 0;
    BTN_N = 5'b10111; tick(10);
    BTN_N = 5'b11111; tick(2);
    BTN_N = 5'b10111; tick(1);
    BTN_N = 5'b11111; tick(2);
    BTN_N = 5'b10111; tick(1);
    BTN_N = 5'b11111; tick(3);
    check("chatter_busy_a", {4'b0, BUSY}, 5'd1);
    tick(2);
    check("chatter_busy_b", {4'b0, BUSY}, 5'd1);
    tick(1);
    check("chatter_idle", {4'b0, BUSY}, 5'd0);
    check("chatter_pulses", 5'(pulse_cnt), 5'd1);
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
